// File: rtl/switch_conditioner_pkg.sv
// Shared constants and types for the switch conditioning front end.
package switch_conditioner_pkg;

  // Default number of consecutive stable cycles before a debounced output follows its input.
  localparam int unsigned c_DEBOUNCE_CNT_DEFAULT = 250;

  // Flops in each raw-input synchroniser; only the last stage is used downstream.
  localparam int unsigned c_SYNC_STAGES = 2;

  // Blink-rate mode as {switch_1, switch_2}, consumed by the LED blinker.
  typedef enum logic [1:0] {
    MODE_100HZ = 2'b00,
    MODE_50HZ  = 2'b01,
    MODE_10HZ  = 2'b10,
    MODE_1HZ   = 2'b11
  } mode_t;

endpackage

// File: rtl/switch_conditioner_debounce_channel.sv
// One debounced input: synchroniser, stability counter, stable register and
// combinational rise/fall strobes that flag the cycle the stable value updates.
module debounce_channel
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned  c_DEBOUNCE_CNT = c_DEBOUNCE_CNT_DEFAULT,
  localparam int unsigned c_CNT_W        = $clog2(c_DEBOUNCE_CNT + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DEBOUNCE_CNT - 1);

  logic [c_SYNC_STAGES-1:0] sync_q;
  logic                     synced;
  logic [c_CNT_W-1:0]       cnt_q, cnt_d;
  logic                     stable_q, stable_d;
  logic                     update;

  assign synced = sync_q[c_SYNC_STAGES-1];

  // Counter runs only while the synchronised input disagrees with the stable value;
  // any agreement clears it, so a single-cycle glitch restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == c_CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end
  end

  // Synchroniser chain, counter and stable register, all cleared by reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[c_SYNC_STAGES-2:0], i_raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign o_stable = stable_q;
  assign o_rise   = update & synced;
  assign o_fall   = update & ~synced;

endmodule

// File: rtl/switch_conditioner.sv
// Front-end input stage: debounces two mode switches and a push-button, toggles
// the enable level on each press and emits registered one-cycle event pulses.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned  c_DEBOUNCE_CNT = c_DEBOUNCE_CNT_DEFAULT,
  parameter logic         c_ENABLE_INIT  = 1'b1,
  localparam int unsigned c_CNT_W        = $clog2(c_DEBOUNCE_CNT + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_switch_raw_1,
  input  logic i_switch_raw_2,
  input  logic i_button_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_button_press,
  output logic o_mode_change
);

  logic sw1_rise, sw1_fall;
  logic sw2_rise, sw2_fall;
  logic btn_stable, btn_rise, unused_btn_fall;
  logic press_q, mode_change_q, enable_q;

  debounce_channel #(
    .c_DEBOUNCE_CNT (c_DEBOUNCE_CNT)
  ) u_switch_1 (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_switch_raw_1),
    .o_stable (o_switch_1),
    .o_rise   (sw1_rise),
    .o_fall   (sw1_fall)
  );

  debounce_channel #(
    .c_DEBOUNCE_CNT (c_DEBOUNCE_CNT)
  ) u_switch_2 (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_switch_raw_2),
    .o_stable (o_switch_2),
    .o_rise   (sw2_rise),
    .o_fall   (sw2_fall)
  );

  debounce_channel #(
    .c_DEBOUNCE_CNT (c_DEBOUNCE_CNT)
  ) u_button (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_raw    (i_button_raw),
    .o_stable (btn_stable),
    .o_rise   (btn_rise),
    .o_fall   (unused_btn_fall)
  );

  // Pulses are registered alongside the stable update; releases neither pulse nor toggle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      press_q       <= 1'b0;
      mode_change_q <= 1'b0;
      enable_q      <= c_ENABLE_INIT;
    end else begin
      press_q       <= btn_rise;
      mode_change_q <= sw1_rise | sw1_fall | sw2_rise | sw2_fall;
      if (btn_rise) begin
        enable_q <= ~enable_q;
      end
    end
  end

  assign o_enable       = enable_q;
  assign o_button_press = press_q;
  assign o_mode_change  = mode_change_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench: stimulus pushes the expected output events (cycle + output
// snapshot) into a queue; a negedge monitor pops and compares whenever the DUT
// shows a pulse or a level change.
module tb_switch_conditioner;

  localparam int unsigned N   = 8;
  localparam int          LAT = N + 2;

  logic clk = 1'b0;
  logic rst;
  logic r1, r2, rb;
  logic o_switch_1, o_switch_2, o_enable, o_button_press, o_mode_change;

  switch_conditioner #(
    .c_DEBOUNCE_CNT (N),
    .c_ENABLE_INIT  (1'b1)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_switch_raw_1 (r1),
    .i_switch_raw_2 (r2),
    .i_button_raw   (rb),
    .o_switch_1     (o_switch_1),
    .o_switch_2     (o_switch_2),
    .o_enable       (o_enable),
    .o_button_press (o_button_press),
    .o_mode_change  (o_mode_change)
  );

  always #5 clk = ~clk;

  // Count of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic sw1;
    logic sw2;
    logic en;
    logic bp;
    logic mc;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic m_en;

  task automatic push_ev(input int at, input logic sw1, input logic sw2, input logic en,
                         input logic bp, input logic mc);
    ev_t e;
    e.at = at; e.sw1 = sw1; e.sw2 = sw2; e.en = en; e.bp = bp; e.mc = mc;
    exp_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any pulse or level change is an observed event, matched in order.
  logic [2:0] prev_lvl;
  always @(negedge clk) begin
    logic [2:0] lvl;
    ev_t        e;
    lvl = {o_switch_1, o_switch_2, o_enable};
    if (mon_en && (o_button_press || o_mode_change || lvl !== prev_lvl)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cyc %0d got sw=%b%b en=%b bp=%b mc=%b, want none",
                 cyc, o_switch_1, o_switch_2, o_enable, o_button_press, o_mode_change);
      end else begin
        e = exp_q.pop_front();
        if (e.at != cyc ||
            {o_switch_1, o_switch_2, o_enable, o_button_press, o_mode_change} !==
            {e.sw1, e.sw2, e.en, e.bp, e.mc}) begin
          fails++;
          $display("FAIL event: got cyc %0d sw=%b%b en=%b bp=%b mc=%b, want cyc %0d sw=%b%b en=%b bp=%b mc=%b",
                   cyc, o_switch_1, o_switch_2, o_enable, o_button_press, o_mode_change,
                   e.at, e.sw1, e.sw2, e.en, e.bp, e.mc);
        end
      end
    end
    prev_lvl = lvl;
  end

  initial begin
    int c;
    rst = 1'b1; r1 = 1'b1; r2 = 1'b1; rb = 1'b1;

    // Reset held 3 cycles with every raw input high.
    step(3);
    check_bit("reset_switch_1", o_switch_1, 1'b0);
    check_bit("reset_switch_2", o_switch_2, 1'b0);
    check_bit("reset_enable", o_enable, 1'b1);
    check_bit("reset_button_press", o_button_press, 1'b0);
    check_bit("reset_mode_change", o_mode_change, 1'b0);

    // Release: all three channels debounce from scratch; button toggles enable.
    mon_en = 1'b1;
    c = cyc; rst = 1'b0;
    m_en = 1'b0;
    push_ev(c + LAT, 1'b1, 1'b1, m_en, 1'b1, 1'b1);
    step(14);
    c = cyc; r1 = 1'b0; r2 = 1'b0; rb = 1'b0;
    push_ev(c + LAT, 1'b0, 1'b0, m_en, 1'b0, 1'b1);
    step(14);

    // Clean switch 2 rise and fall.
    c = cyc; r2 = 1'b1;
    push_ev(c + LAT, 1'b0, 1'b1, m_en, 1'b0, 1'b1);
    step(14);
    c = cyc; r2 = 1'b0;
    push_ev(c + LAT, 1'b0, 1'b0, m_en, 1'b0, 1'b1);
    step(14);

    // Bounce: 7 high, 1 low, 7 high never reaches the threshold.
    r1 = 1'b1; step(7);
    r1 = 1'b0; step(1);
    r1 = 1'b1; step(7);
    r1 = 1'b0; step(14);

    // Button: two held presses, each toggles once; releases are silent.
    for (int i = 0; i < 2; i++) begin
      c = cyc; rb = 1'b1;
      m_en = ~m_en;
      push_ev(c + LAT, 1'b0, 1'b0, m_en, 1'b1, 1'b0);
      step(20);
      rb = 1'b0;
      step(14);
    end

    // Simultaneous switch changes give a single mode pulse each way.
    c = cyc; r1 = 1'b1; r2 = 1'b1;
    push_ev(c + LAT, 1'b1, 1'b1, m_en, 1'b0, 1'b1);
    step(14);
    c = cyc; r1 = 1'b0; r2 = 1'b0;
    push_ev(c + LAT, 1'b0, 1'b0, m_en, 1'b0, 1'b1);
    step(14);

    // Reset on count 5 of a button press: no toggle, then re-debounce after release.
    c = cyc; rb = 1'b1;
    step(7);
    rst = 1'b1;
    if (m_en !== 1'b1) push_ev(c + 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    c = cyc; rst = 1'b0;
    m_en = 1'b0;
    push_ev(c + LAT, 1'b0, 1'b0, m_en, 1'b1, 1'b0);
    step(14);
    rb = 1'b0;
    step(14);

    // Drain any outstanding expectations within a bounded window.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d still pending, want 0 (first due cyc %0d)",
               exp_q.size(), exp_q[0].at);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
